// File: rtl/sram_like_resp_if.sv
`default_nettype none
// ==================================================================
// sram_like_resp_if : SRAM-like request/response bus with test stalls
// rev 1.0
// ==================================================================
interface sram_like_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        addr_stall;
  logic        data_stall;

  modport master (
    output req, wr, size, wstrb, addr, wdata, addr_stall, data_stall,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata, addr_stall, data_stall,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_resp.sv
`default_nettype none
// ==================================================================
// sram_like_resp : word memory answering in-order after a fixed latency
// rev 1.0
// ==================================================================
module sram_like_resp #(
  parameter int MEM_AW  = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            resetn,
  sram_like_resp_if.slave bus
);
  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [3:0]       CD_INIT  = 4'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic [31:0]       mem_q [2**MEM_AW];
  logic              is_wr_q [DEPTH];
  logic              is_wr_d [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [31:0]       data_d  [DEPTH];
  logic [3:0]        cd_q    [DEPTH];
  logic [3:0]        cd_d    [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              pop;
  logic              unused_bits;

  assign idx         = bus.addr[MEM_AW+1:2];
  assign unused_bits = ^{bus.size, bus.addr[1:0], bus.addr[31:MEM_AW+2]};

  // Both handshakes are held low while reset is asserted.
  assign accept = bus.req & ~bus.addr_stall & (count_q < CNT_MAX) & ~resetn;
  assign pop    = (count_q != '0) & (cd_q[rptr_q] == 4'd0) & ~bus.data_stall & ~resetn;

  assign bus.addr_ok = accept;
  assign bus.data_ok = pop;
  assign bus.rdata   = (pop && !is_wr_q[rptr_q]) ? data_q[rptr_q] : 32'd0;

  always_comb begin
    is_wr_d = is_wr_q;
    data_d  = data_q;
    cd_d    = cd_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (cd_q[i] != 4'd0) begin
        cd_d[i] = cd_q[i] - 4'd1;
      end
    end

    // Read data is captured at acceptance, before any write of this edge lands.
    if (accept) begin
      is_wr_d[wptr_q] = bus.wr;
      data_d[wptr_q]  = mem_q[idx];
      cd_d[wptr_q]    = CD_INIT;
      wptr_d          = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end

    if (pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        is_wr_q[i] <= 1'b0;
        data_q[i]  <= 32'd0;
        cd_q[i]    <= 4'd0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      is_wr_q <= is_wr_d;
      data_q  <= data_d;
      cd_q    <= cd_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_like_resp.sv
`default_nettype none
// ==================================================================
// tb_sram_like_resp : two instances (LATENCY 1 and 3) against a queue model
// rev 1.0
// ==================================================================
module tb_sram_like_resp;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 2;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;

  logic        clk        = 1'b0;
  logic        resetn     = 1'b1;
  logic        req        = 1'b0;
  logic        wr         = 1'b0;
  logic [1:0]  size       = 2'd0;
  logic [3:0]  wstrb      = 4'd0;
  logic [31:0] addr       = 32'd0;
  logic [31:0] wdata      = 32'd0;
  logic        addr_stall = 1'b0;
  logic        data_stall = 1'b0;

  sram_like_resp_if if_a ();
  sram_like_resp_if if_b ();

  assign if_a.req = req;               assign if_b.req = req;
  assign if_a.wr = wr;                 assign if_b.wr = wr;
  assign if_a.size = size;             assign if_b.size = size;
  assign if_a.wstrb = wstrb;           assign if_b.wstrb = wstrb;
  assign if_a.addr = addr;             assign if_b.addr = addr;
  assign if_a.wdata = wdata;           assign if_b.wdata = wdata;
  assign if_a.addr_stall = addr_stall; assign if_b.addr_stall = addr_stall;
  assign if_a.data_stall = data_stall; assign if_b.data_stall = data_stall;

  sram_like_resp #(.MEM_AW(MEM_AW), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if_a)
  );

  sram_like_resp #(.MEM_AW(MEM_AW), .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if_b)
  );

  always #5 clk = ~clk;

  // Reference: per instance, a queue of pending answers each tagged with the
  // first cycle it may be returned, plus a plain word array for storage.
  typedef struct packed {
    logic [31:0] data;
    int          ready;
  } resp_t;

  resp_t       q_a[$];
  resp_t       q_b[$];
  logic [31:0] mmem [2][1024];
  logic [31:0] init_w [16];
  logic [31:0] log_b[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        acc     [2];
  logic        obs_aok [2];
  logic        obs_dok [2];
  logic [31:0] obs_rd  [2];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  function automatic resp_t qhead(input int d);
    return (d == 0) ? q_a[0] : q_b[0];
  endfunction

  task automatic model_edge(input int d, input logic aok, input logic dok);
    resp_t       r;
    logic [9:0]  idx;
    if (resetn) begin
      if (d == 0) q_a.delete();
      else        q_b.delete();
      return;
    end
    if (dok) begin
      if (d == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
    end
    if (aok) begin
      idx     = addr[11:2];
      r.data  = wr ? 32'd0 : mmem[d][idx];
      r.ready = cyc + lat(d);
      if (d == 0) q_a.push_back(r);
      else        q_b.push_back(r);
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mmem[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  endtask

  task automatic step();
    logic        aok_e [2];
    logic        dok_e [2];
    logic [31:0] rd_e  [2];
    resp_t       h;
    string       pfx;
    @(negedge clk);
    obs_aok[0] = if_a.addr_ok; obs_dok[0] = if_a.data_ok; obs_rd[0] = if_a.rdata;
    obs_aok[1] = if_b.addr_ok; obs_dok[1] = if_b.data_ok; obs_rd[1] = if_b.rdata;
    for (int d = 0; d < 2; d++) begin
      pfx      = (d == 0) ? "a." : "b.";
      aok_e[d] = req && !addr_stall && !resetn && (qsize(d) < DEPTH);
      dok_e[d] = 1'b0;
      rd_e[d]  = 32'd0;
      if (!resetn && !data_stall && qsize(d) > 0) begin
        h = qhead(d);
        if (cyc >= h.ready) begin
          dok_e[d] = 1'b1;
          rd_e[d]  = h.data;
        end
      end
      check({pfx, "addr_ok"}, {31'd0, obs_aok[d]}, {31'd0, aok_e[d]});
      check({pfx, "data_ok"}, {31'd0, obs_dok[d]}, {31'd0, dok_e[d]});
      check({pfx, "rdata"}, obs_rd[d], rd_e[d]);
      if (obs_dok[d]) last_rd[d] = obs_rd[d];
      acc[d] = aok_e[d];
    end
    if (obs_dok[1]) log_b.push_back(obs_rd[1]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, aok_e[d], dok_e[d]);
    cyc++;
    #1;
  endtask

  task automatic issue(input int tgt, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd, output int n);
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wstrb = s;
    wdata = wd;
    size  = 2'($urandom_range(0, 2));
    n     = 0;
    do begin
      step();
      n++;
    end while (!acc[tgt] && n < 40);
    if (!acc[tgt]) begin
      n_checks++;
      $display("FAIL issue_timeout: addr %h not accepted after %0d cycles, required acceptance", a, n);
    end
  endtask

  task automatic drain_all();
    int n;
    req = 1'b0;
    n   = 0;
    while ((qsize(0) != 0 || qsize(1) != 0) && n < 60) begin
      step();
      n++;
    end
    if (qsize(0) != 0 || qsize(1) != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: responses still pending after %0d cycles, required none", n);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) init_w[i] = $urandom;
    #1;
    req = 1'b1;
    step();
    step();
    check("rst.addr_ok", {31'd0, obs_aok[0]}, 32'd0);
    check("rst.data_ok", {31'd0, obs_dok[0]}, 32'd0);
    check("rst.rdata", obs_rd[0], 32'd0);

    resetn = 1'b0;
    issue(0, 1'b1, 32'h0, 4'hF, init_w[0], n);
    check("first_accept_cycles", n, 32'd1);
    drain_all();
    for (int i = 1; i < 16; i++) begin
      issue(0, 1'b1, 32'(i) << 2, 4'hF, init_w[i], n);
      drain_all();
    end

    // Write then read one word, both with single-cycle latency.
    issue(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, n);
    issue(0, 1'b0, 32'h40, 4'h0, 32'h0, n);
    check("wr_rd.accept_cycles", n, 32'd1);
    check("wr_rd.wr_data_ok", {31'd0, obs_dok[0]}, 32'd1);
    check("wr_rd.wr_rdata", obs_rd[0], 32'd0);
    req = 1'b0;
    step();
    check("wr_rd.rd_data_ok", {31'd0, obs_dok[0]}, 32'd1);
    check("wr_rd.rd_rdata", obs_rd[0], 32'hDEADBEEF);
    drain_all();

    // Byte-lane merge.
    issue(0, 1'b1, 32'h44, 4'hF, 32'h11223344, n);
    issue(0, 1'b1, 32'h44, 4'h2, 32'hAABBCCDD, n);
    issue(0, 1'b0, 32'h44, 4'h0, 32'h0, n);
    drain_all();
    check("strobe.rdata", last_rd[0], 32'h1122CC44);

    // Upper address bits and addr[1:0] do not select the word.
    issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, n);
    drain_all();
    check("alias.0x1000", last_rd[0], init_w[0]);
    issue(0, 1'b0, 32'hFFFF_F007, 4'h0, 32'h0, n);
    drain_all();
    check("alias.0xFFFFF007", last_rd[0], init_w[1]);

    // Full queue on the LATENCY=3 instance with req held high.
    log_b.delete();
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0, n);
    check("full.first_cycles", n, 32'd1);
    issue(1, 1'b0, 32'h4, 4'h0, 32'h0, n);
    check("full.second_cycles", n, 32'd1);
    issue(1, 1'b0, 32'h8, 4'h0, 32'h0, n);
    check("full.third_cycles", n, 32'd3);
    drain_all();
    check("full.resp_count", log_b.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("full.order", (log_b.size() > i) ? log_b[i] : 32'hFFFF_FFFF, init_w[i]);
    end

    // Ready head held by data_stall while the queue is full.
    data_stall = 1'b1;
    issue(0, 1'b0, 32'h40, 4'h0, 32'h0, n);
    issue(0, 1'b0, 32'h44, 4'h0, 32'h0, n);
    addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall.data_ok", {31'd0, obs_dok[0]}, 32'd0);
      check("stall.addr_ok", {31'd0, obs_aok[0]}, 32'd0);
    end
    data_stall = 1'b0;
    step();
    check("stall.release_data_ok", {31'd0, obs_dok[0]}, 32'd1);
    check("stall.release_rdata", obs_rd[0], 32'hDEADBEEF);
    check("stall.no_bypass", {31'd0, obs_aok[0]}, 32'd0);
    drain_all();

    // Reset with two reads outstanding.
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0, n);
    issue(1, 1'b0, 32'h44, 4'h0, 32'h0, n);
    req    = 1'b0;
    resetn = 1'b1;
    step();
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst.b_data_ok", {31'd0, obs_dok[1]}, 32'd0);
      check("midrst.a_data_ok", {31'd0, obs_dok[0]}, 32'd0);
    end
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0, n);
    check("midrst.accept_cycles", n, 32'd1);
    issue(1, 1'b0, 32'h40, 4'h0, 32'h0, n);
    check("midrst.second_accept", n, 32'd1);
    drain_all();
    check("midrst.mem_kept", last_rd[1], 32'hDEADBEEF);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 600; i++) begin
      req        = ($urandom_range(0, 3) != 0);
      wr         = ($urandom_range(0, 3) == 0);
      addr       = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      wstrb      = 4'($urandom);
      wdata      = $urandom;
      size       = 2'($urandom_range(0, 2));
      addr_stall = ($urandom_range(0, 4) == 0);
      data_stall = ($urandom_range(0, 4) == 0);
      resetn     = ($urandom_range(0, 99) == 0);
      step();
    end
    resetn     = 1'b0;
    addr_stall = 1'b0;
    data_stall = 1'b0;
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
